read_arbiter: RTL and testbench

Read-side interconnect arbiter for the M-master/S-slave AXI fabric, companion to the write arbiter. It arbitrates AR requests per slave with round-robin fairness, decodes the target slave from the address, and tracks outstanding reads per slave in issue order. It routes R bursts back to the issuing master, with per-master burst locking, and flags ID mismatches.

---
 rtl/axi_arb_pkg.sv | 49 ++++
 rtl/read_order_fifo.sv | 59 +++++
 rtl/read_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_read_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared arbiter definitions for the read and write AXI arbiters.
// Contents:
//   width_of       - index width for a count of n items (minimum 1 bit)
//   r_own_state_e  - per-master R ownership FSM states
//   order_entry_t  - outstanding-order entry {master, id}, fields sized to the widest user
//   rr_pick        - round-robin search from a start pointer, modulo n
package axi_arb_pkg;

    localparam int ENTRY_FIELD_W = 8;
    localparam int RR_MAX        = 16;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_LOCKED = 1'b1
    } r_own_state_e;

    typedef struct packed {
        logic [ENTRY_FIELD_W-1:0] master;
        logic [ENTRY_FIELD_W-1:0] id;
    } order_entry_t;

    typedef struct packed {
        logic                     found;
        logic [ENTRY_FIELD_W-1:0] idx;
    } rr_result_t;

    // First set bit of req[0..n-1] at or after ptr, wrapping at n.
    function automatic rr_result_t rr_pick(input logic [RR_MAX-1:0] req,
                                           input int n, input int ptr);
        rr_result_t r;
        int         c;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (i < n && !r.found) begin
                c = (ptr + i) % n;
                if (req[c]) begin
                    r.found = 1'b1;
                    r.idx   = ENTRY_FIELD_W'(c);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/read_order_fifo.sv
// In-order record of outstanding reads for one slave.
// Ports:
//   clk, clr          - clock, async active-low reset (empties the FIFO)
//   push, push_data   - append an entry (ignored when full)
//   pop               - drop the head entry (ignored when empty)
//   head              - oldest entry
//   count/full/empty  - occupancy
module read_order_fifo
    import axi_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = width_of(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  order_entry_t  push_data,
    input  logic          pop,
    output order_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    order_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (!push_ok && pop_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/read_arbiter.sv
// Read-side M-master / S-slave AXI arbiter.
// Ports:
//   clk, clr                          - clock, async active-low reset
//   AR_valid_f/AR_addr_f/AR_id_f      - per-master read requests
//   AR_grant_f                        - per-master AR accept (combinational)
//   AR_sel_f                          - per-master decoded slave index
//   R_valid_f/R_last_f/R_id_f         - per-slave read data
//   R_ready_f                         - per-master read-data ready
//   R_grant_f/R_sel_f                 - per-slave beat transfer and destination master
//   id_err_f                          - per-slave sticky returned-ID mismatch
//
// Per-master R ownership FSM:
//   state    | meaning
//   R_IDLE   | no burst in progress; ready slaves compete round-robin from rrr_ptr
//   R_LOCKED | mid-burst; only lock_slv may deliver beats to this master
module read_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int M                     = 2,
    parameter  int S                     = 2,
    parameter  int NUM_OUTSTANDING_TRANS = 2,
    parameter  int ADDR_WIDTH            = 32,
    parameter  int SLAVE_SEL_LSB         = 16,
    localparam int IW                    = width_of(NUM_OUTSTANDING_TRANS),
    localparam int SW                    = width_of(S),
    localparam int MW                    = width_of(M),
    localparam int CW                    = $clog2(NUM_OUTSTANDING_TRANS + 1)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [M-1:0]            AR_valid_f,
    input  logic [M*ADDR_WIDTH-1:0] AR_addr_f,
    input  logic [M*IW-1:0]         AR_id_f,
    output logic [M-1:0]            AR_grant_f,
    output logic [M*SW-1:0]         AR_sel_f,
    input  logic [S-1:0]            R_valid_f,
    input  logic [S-1:0]            R_last_f,
    input  logic [S*IW-1:0]         R_id_f,
    input  logic [M-1:0]            R_ready_f,
    output logic [S-1:0]            R_grant_f,
    output logic [S*MW-1:0]         R_sel_f,
    output logic [S-1:0]            id_err_f
);

    logic [SW-1:0] ar_sel    [M];
    logic          ar_push   [S];
    logic [MW-1:0] ar_win    [S];
    logic [MW-1:0] rr_ptr    [S];
    order_entry_t  head      [S];
    logic [CW-1:0] fifo_cnt  [S];
    logic          full      [S];
    logic          empty     [S];
    logic [MW-1:0] hd_master [S];
    logic [IW-1:0] hd_id     [S];
    logic [S-1:0]  r_gnt_m   [M];
    logic [M-1:0]  ar_grant;
    logic [S-1:0]  r_grant;
    logic [S-1:0]  r_pop;
    logic [S-1:0]  id_err;
    logic          unused_addr;

    assign unused_addr = ^AR_addr_f;

    for (genvar m = 0; m < M; m++) begin : g_dec
        assign ar_sel[m]             = AR_addr_f[m*ADDR_WIDTH + SLAVE_SEL_LSB +: SW];
        assign AR_sel_f[m*SW +: SW]  = ar_sel[m];
    end

    for (genvar s = 0; s < S; s++) begin : g_slave
        logic [RR_MAX-1:0] ar_req;
        rr_result_t        ar_pick;
        order_entry_t      ar_entry;
        logic              unused_s;

        // A full FIFO blocks AR even when it pops this cycle.
        always_comb begin
            ar_req = '0;
            for (int m = 0; m < M; m++)
                ar_req[m] = AR_valid_f[m] && (ar_sel[m] == SW'(s)) && !full[s];
        end

        assign ar_pick    = rr_pick(ar_req, M, int'(rr_ptr[s]));
        assign ar_push[s] = ar_pick.found && clr;
        assign ar_win[s]  = ar_pick.idx[MW-1:0];

        always_comb begin
            ar_entry.master = ENTRY_FIELD_W'(ar_win[s]);
            ar_entry.id     = ENTRY_FIELD_W'(AR_id_f[int'(ar_win[s])*IW +: IW]);
        end

        read_order_fifo #(.DEPTH(NUM_OUTSTANDING_TRANS)) u_fifo (
            .clk       (clk),
            .clr       (clr),
            .push      (ar_push[s]),
            .push_data (ar_entry),
            .pop       (r_pop[s]),
            .head      (head[s]),
            .count     (fifo_cnt[s]),
            .full      (full[s]),
            .empty     (empty[s])
        );

        assign hd_master[s]         = head[s].master[MW-1:0];
        assign hd_id[s]             = head[s].id[IW-1:0];
        assign R_sel_f[s*MW +: MW]  = empty[s] ? '0 : hd_master[s];

        assign unused_s = ^{fifo_cnt[s], head[s].master[ENTRY_FIELD_W-1:MW],
                            head[s].id[ENTRY_FIELD_W-1:IW], ar_pick.idx[ENTRY_FIELD_W-1:MW]};
    end

    for (genvar m = 0; m < M; m++) begin : g_master
        r_own_state_e      state;
        r_own_state_e      state_nxt;
        logic [SW-1:0]     lock_slv;
        logic [SW-1:0]     lock_slv_nxt;
        logic [SW-1:0]     rrr_ptr;
        logic [SW-1:0]     rrr_ptr_nxt;
        logic [RR_MAX-1:0] r_req;
        rr_result_t        r_pick;
        logic [S-1:0]      r_gnt;
        logic              unused_pick;

        always_comb begin
            r_req = '0;
            for (int s = 0; s < S; s++)
                r_req[s] = R_valid_f[s] && !empty[s] && (hd_master[s] == MW'(m));
        end

        assign r_pick      = rr_pick(r_req, S, int'(rrr_ptr));
        assign unused_pick = ^r_pick.idx[ENTRY_FIELD_W-1:SW];

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                state    <= R_IDLE;
                lock_slv <= '0;
                rrr_ptr  <= '0;
            end else begin
                state    <= state_nxt;
                lock_slv <= lock_slv_nxt;
                rrr_ptr  <= rrr_ptr_nxt;
            end
        end

        always_comb begin
            state_nxt    = state;
            lock_slv_nxt = lock_slv;
            rrr_ptr_nxt  = rrr_ptr;
            for (int s = 0; s < S; s++) begin
                if (r_gnt[s]) begin
                    if (R_last_f[s]) begin
                        state_nxt   = R_IDLE;
                        rrr_ptr_nxt = SW'((s + 1) % S);
                    end else begin
                        state_nxt    = R_LOCKED;
                        lock_slv_nxt = SW'(s);
                    end
                end
            end
        end

        always_comb begin
            r_gnt = '0;
            if (clr && R_ready_f[m]) begin
                if (state == R_LOCKED) begin
                    if (r_req[lock_slv]) r_gnt[lock_slv] = 1'b1;
                end else if (r_pick.found) begin
                    r_gnt[r_pick.idx[SW-1:0]] = 1'b1;
                end
            end
        end

        assign r_gnt_m[m] = r_gnt;
    end

    always_comb begin
        ar_grant = '0;
        for (int s = 0; s < S; s++)
            if (ar_push[s]) ar_grant[ar_win[s]] = 1'b1;
    end

    always_comb begin
        r_grant = '0;
        for (int m = 0; m < M; m++) r_grant = r_grant | r_gnt_m[m];
    end

    assign r_pop      = r_grant & R_last_f;
    assign AR_grant_f = ar_grant;
    assign R_grant_f  = r_grant;
    assign id_err_f   = id_err;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            id_err <= '0;
            for (int s = 0; s < S; s++) rr_ptr[s] <= '0;
        end else begin
            for (int s = 0; s < S; s++) begin
                if (ar_push[s]) rr_ptr[s] <= MW'((int'(ar_win[s]) + 1) % M);
                // Mismatched beats are still delivered; only the flag records them.
                if (r_grant[s] && (R_id_f[s*IW +: IW] != hd_id[s])) id_err[s] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
module tb_read_arbiter;

    localparam int M  = 2;
    localparam int S  = 2;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int IW = 1;
    localparam int SW = 1;
    localparam int MW = 1;

    logic            clk = 1'b0;
    logic            clr;
    logic [M-1:0]    AR_valid_f;
    logic [M*AW-1:0] AR_addr_f;
    logic [M*IW-1:0] AR_id_f;
    logic [M-1:0]    AR_grant_f;
    logic [M*SW-1:0] AR_sel_f;
    logic [S-1:0]    R_valid_f;
    logic [S-1:0]    R_last_f;
    logic [S*IW-1:0] R_id_f;
    logic [M-1:0]    R_ready_f;
    logic [S-1:0]    R_grant_f;
    logic [S*MW-1:0] R_sel_f;
    logic [S-1:0]    id_err_f;

    read_arbiter #(.M(M), .S(S), .NUM_OUTSTANDING_TRANS(N), .ADDR_WIDTH(AW), .SLAVE_SEL_LSB(16)) dut (
        .clk(clk), .clr(clr),
        .AR_valid_f(AR_valid_f), .AR_addr_f(AR_addr_f), .AR_id_f(AR_id_f),
        .AR_grant_f(AR_grant_f), .AR_sel_f(AR_sel_f),
        .R_valid_f(R_valid_f), .R_last_f(R_last_f), .R_id_f(R_id_f),
        .R_ready_f(R_ready_f), .R_grant_f(R_grant_f), .R_sel_f(R_sel_f),
        .id_err_f(id_err_f)
    );

    always #5 clk = ~clk;

    typedef struct packed {int master; int id;} ent_t;

    ent_t         mq   [S][$];   // reference outstanding reads, issue order
    int           sb_q [S][$];   // scoreboard: expected destination per burst
    int           rr   [S];
    int           rrr  [M];
    int           lock [M];      // -1 when the master is not mid-burst
    bit           err  [S];
    int           errors = 0;
    int           checks = 0;
    logic [S-1:0] exp_rg;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dec(input int m);
        return int'((AR_addr_f[m*AW +: AW] >> 16) % S);
    endfunction

    function automatic bit cand(input int s, input int m);
        return R_valid_f[s] && mq[s].size() > 0 && mq[s][0].master == m;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            mq[s].delete();
            sb_q[s].delete();
            rr[s]  = 0;
            err[s] = 0;
        end
        for (int m = 0; m < M; m++) begin
            rrr[m]  = 0;
            lock[m] = -1;
        end
    endtask

    // Check the settled outputs of this cycle, then advance the model to the next edge.
    task automatic step(input int pre = 3);
        int ar_win [S];
        int exp_ar, exp_sel, exp_rsel, exp_err, s, m;
        bit found;
        #pre;
        if (!clr) model_reset();
        exp_ar = 0;
        for (int t = 0; t < S; t++) begin
            ar_win[t] = -1;
            if (clr && mq[t].size() < N) begin
                for (int k = 0; k < M; k++) begin
                    m = (rr[t] + k) % M;
                    if (ar_win[t] < 0 && AR_valid_f[m] && dec(m) == t) ar_win[t] = m;
                end
                if (ar_win[t] >= 0) exp_ar |= 1 << ar_win[t];
            end
        end
        exp_rg = '0;
        for (int u = 0; u < M; u++) begin
            if (clr && R_ready_f[u]) begin
                if (lock[u] >= 0) begin
                    if (cand(lock[u], u)) exp_rg[lock[u]] = 1'b1;
                end else begin
                    found = 0;
                    for (int k = 0; k < S; k++) begin
                        s = (rrr[u] + k) % S;
                        if (!found && cand(s, u)) begin
                            found = 1;
                            exp_rg[s] = 1'b1;
                        end
                    end
                end
            end
        end
        exp_sel = 0; exp_rsel = 0; exp_err = 0;
        for (int u = 0; u < M; u++) exp_sel |= dec(u) << (u * SW);
        for (int t = 0; t < S; t++) begin
            if (mq[t].size() > 0) exp_rsel |= mq[t][0].master << (t * MW);
            if (err[t]) exp_err |= 1 << t;
        end
        check("ar_grant", AR_grant_f, exp_ar);
        check("ar_sel", AR_sel_f, exp_sel);
        check("r_grant", R_grant_f, exp_rg);
        check("r_sel", R_sel_f, exp_rsel);
        check("id_err", id_err_f, exp_err);
        for (int t = 0; t < S; t++) begin
            if (exp_rg[t]) begin
                m = mq[t][0].master;
                if (int'(R_id_f[t*IW +: IW]) != mq[t][0].id) err[t] = 1;
                if (R_last_f[t]) begin
                    void'(mq[t].pop_front());
                    lock[m] = -1;
                    rrr[m]  = (t + 1) % S;
                end else begin
                    lock[m] = t;
                end
            end
        end
        for (int t = 0; t < S; t++) begin
            if (ar_win[t] >= 0) begin
                mq[t].push_back('{master: ar_win[t], id: int'(AR_id_f[ar_win[t]*IW +: IW])});
                sb_q[t].push_back(ar_win[t]);
                rr[t] = (ar_win[t] + 1) % M;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed burst must go to the master that issued the oldest read.
    always @(negedge clk) begin
        for (int s = 0; s < S; s++) begin
            if (clr && R_grant_f[s] && R_last_f[s]) begin
                if (sb_q[s].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow slave %0d at %0t: R_last granted, expected no outstanding read", s, $time);
                end else begin
                    int e;
                    e = sb_q[s].pop_front();
                    check("sb_r_dest", int'(R_sel_f[s*MW +: MW]), e);
                end
            end
        end
    end

    task automatic set_ar(input int m, input bit v, input logic [31:0] a, input int id);
        AR_valid_f[m] = v;
        AR_addr_f[m*AW +: AW] = a;
        AR_id_f[m*IW +: IW] = IW'(id);
    endtask

    task automatic set_r(input int s, input bit v, input bit last, input int id);
        R_valid_f[s] = v;
        R_last_f[s]  = last;
        R_id_f[s*IW +: IW] = IW'(id);
    endtask

    task automatic idle();
        AR_valid_f = '0;
        R_valid_f  = '0;
        R_last_f   = '0;
    endtask

    function automatic int head_id(input int s);
        return (mq[s].size() > 0) ? mq[s][0].id : 0;
    endfunction

    task automatic drain(input int s);
        for (int i = 0; i < 8; i++) begin
            if (mq[s].size() > 0) begin
                set_r(s, 1, 1, head_id(s));
                step();
            end
        end
        set_r(s, 0, 0, 0);
    endtask

    initial begin
        int beats [S];
        clr = 1'b0;
        AR_valid_f = '0; AR_addr_f = '0; AR_id_f = '0;
        R_valid_f = '0; R_last_f = '0; R_id_f = '0; R_ready_f = '1;
        model_reset();
        @(posedge clk); #1;
        repeat (2) step();
        clr = 1'b1;
        step();

        // Single read
        set_ar(0, 1, 32'h0000_0000, 0);
        step();
        set_ar(0, 0, 32'h0, 0);
        set_r(0, 1, 1, 0);
        step();
        idle();
        step();

        // Round-robin on slave 1 until full, then one pop re-opens it
        set_ar(0, 1, 32'h0001_0000, 0);
        set_ar(1, 1, 32'h0001_0000, 1);
        repeat (4) step();
        set_r(1, 1, 1, head_id(1));
        step();
        set_r(1, 0, 0, 0);
        step();
        idle();
        drain(1);

        // R contention with mid-burst backpressure
        set_ar(0, 1, 32'h0000_0000, 0);
        step();
        set_ar(0, 1, 32'h0001_0000, 1);
        step();
        idle();
        beats[0] = 0; beats[1] = 0;
        for (int i = 0; i < 14; i++) begin
            for (int s = 0; s < S; s++) begin
                if (beats[s] < 4 && mq[s].size() > 0) set_r(s, 1, beats[s] == 3, head_id(s));
                else set_r(s, 0, 0, 0);
            end
            R_ready_f[0] = (i != 2 && i != 6);
            step();
            for (int s = 0; s < S; s++) if (exp_rg[s]) beats[s]++;
        end
        R_ready_f = '1;
        check("contention_s0_beats", beats[0], 4);
        check("contention_s1_beats", beats[1], 4);
        idle();

        // ID mismatch: issued id 1, returned id 0
        set_ar(1, 1, 32'h0000_0000, 1);
        step();
        idle();
        set_r(0, 1, 1, 0);
        step();
        idle();
        repeat (3) step();
        check("id_err_sticky", id_err_f[0], 1);

        // Reset mid-burst
        set_ar(0, 1, 32'h0000_0000, 0);
        step();
        idle();
        set_r(0, 1, 0, 0);
        step();
        set_r(0, 1, 0, 0);
        clr = 1'b0;
        #1;
        check("rst_ar_grant", AR_grant_f, 0);
        check("rst_r_grant", R_grant_f, 0);
        check("rst_r_sel", R_sel_f, 0);
        check("rst_id_err", id_err_f, 0);
        step(2);
        clr = 1'b1;
        idle();
        set_ar(0, 1, 32'h0000_0000, 0);
        step();
        idle();
        drain(0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 149) != 0);
            for (int m = 0; m < M; m++)
                set_ar(m, $urandom_range(0, 1) == 1,
                       {$urandom_range(0, 65535) & 32'hFFFF, 16'($urandom)}, int'($urandom_range(0, 1)));
            for (int s = 0; s < S; s++)
                set_r(s, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                      ($urandom_range(0, 7) != 0) ? head_id(s) : int'($urandom_range(0, 1)));
            for (int m = 0; m < M; m++) R_ready_f[m] = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
